// File: rtl/alu_divide_int_uint64.sv
// alu_divide_int_uint64: iterative radix-2 restoring divider, signed/unsigned, quotient or remainder.
// One quotient bit per clock; WIDTH+3 cycles from accepted start to the ready pulse.
module alu_divide_int_uint64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clean,
    input  logic             start,
    input  logic             isSigned,
    input  logic             getRemainder,
    input  logic [WIDTH-1:0] numA,
    input  logic [WIDTH-1:0] numB,
    output logic [WIDTH-1:0] numC,
    output logic             isNowTickReady,
    output logic             divByZero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
    state_t r_state, w_next;

    logic [WIDTH-1:0] r_a, r_b, r_quo, r_rem, r_div, r_numc;
    logic             r_signed, r_getrem, r_sign_a, r_sign_b, r_ready, r_dbz;
    logic [CW-1:0]    r_cnt;

    logic             w_sign_a, w_sign_b, w_ge;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_sub, w_q, w_r;
    logic [WIDTH:0]   w_shift;

    assign w_sign_a = r_signed & r_a[WIDTH-1];
    assign w_sign_b = r_signed & r_b[WIDTH-1];
    assign w_mag_a  = w_sign_a ? -r_a : r_a;
    assign w_mag_b  = w_sign_b ? -r_b : r_b;
    // Partial remainder stays below the divisor, so the shifted value needs only one extra bit.
    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_ge     = w_shift >= {1'b0, r_div};
    assign w_sub    = w_shift[WIDTH-1:0] - r_div;
    assign w_q      = (r_sign_a ^ r_sign_b) ? -r_quo : r_quo;
    assign w_r      = r_sign_a ? -r_rem : r_rem;

    assign numC           = r_numc;
    assign isNowTickReady = r_ready;
    assign divByZero      = r_dbz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = start ? PREP : IDLE;
            PREP:       w_next = (r_b == '0) ? DONE : CALC;
            CALC:       w_next = (r_cnt == LAST) ? FIX : CALC;
            FIX:        w_next = DONE;
            default:    w_next = IDLE;
        endcase
        if (clean) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_numc   <= '0;
            r_signed <= 1'b0;
            r_getrem <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_ready  <= 1'b0;
            r_dbz    <= 1'b0;
            r_cnt    <= '0;
        end else if (clean) begin
            r_numc  <= '0;
            r_ready <= 1'b0;
            r_dbz   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_ready <= (w_next == DONE);
            case (r_state)
                IDLE, DONE: if (start) begin
                    r_a      <= numA;
                    r_b      <= numB;
                    r_signed <= isSigned;
                    r_getrem <= getRemainder;
                    r_dbz    <= 1'b0;
                end
                PREP: begin
                    r_sign_a <= w_sign_a;
                    r_sign_b <= w_sign_b;
                    r_quo    <= w_mag_a;
                    r_div    <= w_mag_b;
                    r_rem    <= '0;
                    r_cnt    <= '0;
                    if (r_b == '0) begin
                        r_numc <= r_getrem ? r_a : '1;
                        r_dbz  <= 1'b1;
                    end
                end
                CALC: begin
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                    r_cnt <= r_cnt + CW'(1);
                end
                FIX: r_numc <= r_getrem ? w_r : w_q;
                default: ;
            endcase
        end
    end
endmodule
